// File: rtl/fft_cmul_pipe_if.sv
// Handshake and data bundle for the pipelined complex twiddle multiplier.
// master = producer/consumer side, slave = the multiplier itself.
interface fft_cmul_pipe_if #(
  parameter int DW   = 17,
  parameter int TW   = 8,
  parameter int TAGW = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [DW-1:0]   in_re;
  logic signed [DW-1:0]   in_im;
  logic signed [TW-1:0]   tw_re;
  logic signed [TW-1:0]   tw_im;
  logic [TAGW-1:0]        in_tag;
  logic                   round_en;
  logic                   sat_en;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [DW-1:0]   out_re;
  logic signed [DW-1:0]   out_im;
  logic [TAGW-1:0]        out_tag;
  logic                   ovf;
  logic                   ovf_clr;

  modport master (
    output in_valid, in_re, in_im, tw_re, tw_im, in_tag, round_en, sat_en,
    output out_ready, ovf_clr,
    input  in_ready, out_valid, out_re, out_im, out_tag, ovf
  );

  modport slave (
    input  in_valid, in_re, in_im, tw_re, tw_im, in_tag, round_en, sat_en,
    input  out_ready, ovf_clr,
    output in_ready, out_valid, out_re, out_im, out_tag, ovf
  );
endinterface

// File: rtl/fft_cmul_pipe.sv
// Three-stage pipelined complex multiply (data x twiddle) with per-sample
// rounding/saturation, global-stall valid/ready flow control and sticky overflow.
module fft_cmul_pipe #(
  parameter int DW   = 17,
  parameter int TW   = 8,
  parameter int TAGW = 4
) (
  input logic            clk,
  input logic            rst_n,
  fft_cmul_pipe_if.slave bus
);
  localparam int PW = DW + TW;
  localparam int SW = DW + TW + 1;
  localparam int RW = DW + 2;
  localparam logic signed [SW-1:0] HALF = SW'(1) << (TW - 2);
  localparam logic signed [RW-1:0] MAXV = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {3'b111, {(DW-1){1'b0}}};

  logic                 en;

  logic                 s1_valid_q;
  logic signed [DW-1:0] s1_re_q, s1_im_q;
  logic signed [TW-1:0] s1_twr_q, s1_twi_q;
  logic [TAGW-1:0]      s1_tag_q;
  logic                 s1_rnd_q, s1_sat_q;

  logic                 s2_valid_q;
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  logic [TAGW-1:0]      s2_tag_q;
  logic                 s2_rnd_q, s2_sat_q;

  logic signed [SW-1:0] sum_re_d, sum_im_d;
  logic [DW-1:0]        re_d, im_d;
  logic                 ovf_re_d, ovf_im_d;

  logic                 out_valid_q;
  logic signed [DW-1:0] out_re_q, out_im_q;
  logic [TAGW-1:0]      out_tag_q;
  logic                 ovf_q, ovf_d;

  // Returns {overflow, result}: round, floor-shift back to Q1.(DW-1), then clamp or wrap.
  function automatic logic [DW:0] scale(input logic signed [SW-1:0] s,
                                        input logic rnd, input logic sat);
    logic signed [SW-1:0] r;
    logic signed [RW-1:0] sh;
    logic                 hi, lo;
    logic [DW-1:0]        v;
    r  = rnd ? s + HALF : s;
    sh = RW'(r >>> (TW - 1));
    hi = sh > MAXV;
    lo = sh < MINV;
    if (sat && hi)      v = {1'b0, {(DW-1){1'b1}}};
    else if (sat && lo) v = {1'b1, {(DW-1){1'b0}}};
    else                v = sh[DW-1:0];
    return {hi || lo, v};
  endfunction

  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  assign p_rr_d = PW'(s1_re_q) * PW'(s1_twr_q);
  assign p_ii_d = PW'(s1_im_q) * PW'(s1_twi_q);
  assign p_ri_d = PW'(s1_re_q) * PW'(s1_twi_q);
  assign p_ir_d = PW'(s1_im_q) * PW'(s1_twr_q);

  always_comb begin
    sum_re_d = SW'(p_rr_q) - SW'(p_ii_q);
    sum_im_d = SW'(p_ri_q) + SW'(p_ir_q);
    {ovf_re_d, re_d} = scale(sum_re_d, s2_rnd_q, s2_sat_q);
    {ovf_im_d, im_d} = scale(sum_im_d, s2_rnd_q, s2_sat_q);
  end

  // Set has priority over clear; clear works even while the pipe is stalled.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.ovf_clr) ovf_d = 1'b0;
    if (en && s2_valid_q && (ovf_re_d || ovf_im_d)) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      s1_twr_q    <= '0;
      s1_twi_q    <= '0;
      s1_tag_q    <= '0;
      s1_rnd_q    <= 1'b0;
      s1_sat_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      p_rr_q      <= '0;
      p_ii_q      <= '0;
      p_ri_q      <= '0;
      p_ir_q      <= '0;
      s2_tag_q    <= '0;
      s2_rnd_q    <= 1'b0;
      s2_sat_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_tag_q   <= '0;
    end else if (en) begin
      s1_valid_q  <= bus.in_valid;
      s1_re_q     <= bus.in_re;
      s1_im_q     <= bus.in_im;
      s1_twr_q    <= bus.tw_re;
      s1_twi_q    <= bus.tw_im;
      s1_tag_q    <= bus.in_tag;
      s1_rnd_q    <= bus.round_en;
      s1_sat_q    <= bus.sat_en;
      s2_valid_q  <= s1_valid_q;
      p_rr_q      <= p_rr_d;
      p_ii_q      <= p_ii_d;
      p_ri_q      <= p_ri_d;
      p_ir_q      <= p_ir_d;
      s2_tag_q    <= s1_tag_q;
      s2_rnd_q    <= s1_rnd_q;
      s2_sat_q    <= s1_sat_q;
      out_valid_q <= s2_valid_q;
      out_re_q    <= re_d;
      out_im_q    <= im_d;
      out_tag_q   <= s2_tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_fft_cmul_pipe.sv
// Self-checking bench for fft_cmul_pipe: directed corners plus randomized
// traffic scored against an integer-arithmetic reference model.
module tb_fft_cmul_pipe;
  localparam int DW   = 17;
  localparam int TW   = 8;
  localparam int TAGW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_cmul_pipe_if #(.DW(DW), .TW(TW), .TAGW(TAGW)) bus ();
  fft_cmul_pipe #(.DW(DW), .TW(TW), .TAGW(TAGW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    longint re;
    longint im;
    int     tag;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];

  // Exact product, optional +half LSB, floor division, then clamp or modulo-wrap.
  function automatic longint scale_m(longint num, bit rnd, bit sat);
    longint d, q, m, w;
    d = longint'(1) << (TW - 1);
    m = longint'(1) << DW;
    if (rnd) num = num + d / 2;
    q = num / d;
    if ((num % d != 0) && (num < 0)) q = q - 1;
    if (sat) begin
      if (q > m / 2 - 1) return m / 2 - 1;
      if (q < -(m / 2)) return -(m / 2);
      return q;
    end
    w = ((q % m) + m) % m;
    if (w >= m / 2) w = w - m;
    return w;
  endfunction

  function automatic res_t model(longint a, longint b, longint c, longint e,
                                 int tag, bit rnd, bit sat);
    res_t r;
    r.re  = scale_m(a * c - b * e, rnd, sat);
    r.im  = scale_m(a * e + b * c, rnd, sat);
    r.tag = tag;
    return r;
  endfunction

  // Records every accepted input (as a model prediction) and every transferred output.
  always @(posedge clk) begin
    res_t g;
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_re, bus.in_im, bus.tw_re, bus.tw_im,
                              int'(bus.in_tag), bus.round_en, bus.sat_en));
      if (bus.out_valid && bus.out_ready) begin
        g.re  = bus.out_re;
        g.im  = bus.out_im;
        g.tag = int'(bus.out_tag);
        got_q.push_back(g);
        $display("txn out re=%0d im=%0d tag=%0d ovf=%0b", g.re, g.im, g.tag, bus.ovf);
      end
    end
  end

  task automatic set_in(input longint a, input longint b, input longint c, input longint e,
                        input int tag, input bit rnd, input bit sat);
    bus.in_re    = a[DW-1:0];
    bus.in_im    = b[DW-1:0];
    bus.tw_re    = c[TW-1:0];
    bus.tw_im    = e[TW-1:0];
    bus.in_tag   = tag[TAGW-1:0];
    bus.round_en = rnd;
    bus.sat_en   = sat;
  endtask

  task automatic set_random();
    logic signed [DW-1:0] ra, rb;
    logic signed [TW-1:0] rc, rd;
    int                   rt;
    ra = DW'($urandom);
    rb = DW'($urandom);
    rc = TW'($urandom);
    rd = TW'($urandom);
    rt = int'($urandom_range(0, (1 << TAGW) - 1));
    set_in(ra, rb, rc, rd, rt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Presents one sample; lat = edges from the accepting edge (counted as 1) to out_valid, -1 on timeout.
  task automatic run_one(input longint a, input longint b, input longint c, input longint e,
                         input int tag, input bit rnd, input bit sat, output int lat);
    bit acc;
    int n;
    set_in(a, b, c, e, tag, rnd, sat);
    bus.in_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!acc || !bus.out_valid) lat = -1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
    set_in(0, 0, 0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.out_re !== '0) $display("FAIL reset_out_re: got %0d want 0", bus.out_re); else pass_cnt++;
    chk_cnt++; if (bus.out_im !== '0) $display("FAIL reset_out_im: got %0d want 0", bus.out_im); else pass_cnt++;
    chk_cnt++; if (bus.out_tag !== '0) $display("FAIL reset_out_tag: got %0d want 0", bus.out_tag); else pass_cnt++;
    chk_cnt++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", bus.ovf); else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_rounding();
    int  a_t[4] = '{3, 3, -3, -3};
    bit  r_t[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int  e_t[4] = '{1, 2, -2, -1};
    int  lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_one(a_t[i], 0, 64, 0, i, r_t[i], 1'b0, lat);
      chk_cnt++; if (lat != 3) $display("FAIL round_latency[%0d]: got %0d want 3", i, lat); else pass_cnt++;
      chk_cnt++;
      if (longint'(bus.out_re) !== longint'(e_t[i]))
        $display("FAIL round_out_re[%0d]: got %0d want %0d", i, bus.out_re, e_t[i]);
      else pass_cnt++;
    end
    idle(2);
  endtask

  task automatic test_overflow();
    int lat;
    bus.out_ready = 1'b1;
    bus.ovf_clr = 1'b1; @(posedge clk); #1; bus.ovf_clr = 1'b0;
    run_one(-65536, 0, -128, 0, 5, 1'b0, 1'b1, lat);
    chk_cnt++; if (longint'(bus.out_re) !== 65535) $display("FAIL ovf_sat_re: got %0d want 65535", bus.out_re); else pass_cnt++;
    chk_cnt++; if (longint'(bus.out_im) !== 0) $display("FAIL ovf_sat_im: got %0d want 0", bus.out_im); else pass_cnt++;
    chk_cnt++; if (bus.ovf !== 1'b1) $display("FAIL ovf_sat_flag: got %0b want 1", bus.ovf); else pass_cnt++;
    run_one(-65536, 0, -128, 0, 6, 1'b0, 1'b0, lat);
    chk_cnt++; if (longint'(bus.out_re) !== -65536) $display("FAIL ovf_wrap_re: got %0d want -65536", bus.out_re); else pass_cnt++;
    chk_cnt++; if (bus.ovf !== 1'b1) $display("FAIL ovf_wrap_flag: got %0b want 1", bus.ovf); else pass_cnt++;
    bus.ovf_clr = 1'b1; @(posedge clk); #1; bus.ovf_clr = 1'b0;
    chk_cnt++; if (bus.ovf !== 1'b0) $display("FAIL ovf_clear: got %0b want 0", bus.ovf); else pass_cnt++;
    // Overflowing sample reaches the output register on the same edge as a clear pulse.
    set_in(-65536, 0, -128, 0, 7, 1'b0, 1'b1);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk_cnt++; if (bus.ovf !== 1'b0) $display("FAIL ovf_pre_collide: got %0b want 0", bus.ovf); else pass_cnt++;
    bus.ovf_clr = 1'b1;
    @(posedge clk); #1;
    bus.ovf_clr = 1'b0;
    chk_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL ovf_collide_valid: got %0b want 1", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.ovf !== 1'b1) $display("FAIL ovf_set_wins: got %0b want 1", bus.ovf); else pass_cnt++;
    idle(2);
    bus.ovf_clr = 1'b1; @(posedge clk); #1; bus.ovf_clr = 1'b0;
  endtask

  task automatic compare_queues(input string name, input int want_n);
    chk_cnt++;
    if (got_q.size() != want_n || exp_q.size() != want_n)
      $display("FAIL %s_count: got %0d results, %0d accepted, want %0d", name, got_q.size(), exp_q.size(), want_n);
    else pass_cnt++;
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      chk_cnt++;
      if (got_q[j].re !== exp_q[j].re || got_q[j].im !== exp_q[j].im || got_q[j].tag !== exp_q[j].tag)
        $display("FAIL %s[%0d]: got (%0d,%0d,t%0d) want (%0d,%0d,t%0d)", name, j,
                 got_q[j].re, got_q[j].im, got_q[j].tag, exp_q[j].re, exp_q[j].im, exp_q[j].tag);
      else pass_cnt++;
    end
  endtask

  task automatic test_streaming();
    int k, first;
    bus.out_ready = 1'b1;
    idle(3);
    exp_q.delete(); got_q.delete();
    k = 0; first = -1;
    for (int i = 0; i < 16; i++) begin
      set_random();
      bus.in_valid = 1'b1;
      @(posedge clk); #1; k++;
      if (bus.out_valid && first < 0) first = k;
    end
    bus.in_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1; k++;
      if (bus.out_valid && first < 0) first = k;
    end
    chk_cnt++; if (first != 3) $display("FAIL stream_latency: got %0d want 3", first); else pass_cnt++;
    compare_queues("stream", 16);
  endtask

  task automatic test_back_to_back_backpressure();
    bit                   stalled;
    logic signed [DW-1:0] p_re, p_im;
    logic [TAGW-1:0]      p_tag;
    int                   n;
    idle(3);
    exp_q.delete(); got_q.delete();
    stalled = 1'b0; p_re = '0; p_im = '0; p_tag = '0;
    for (int i = 0; i < 60; i++) begin
      if (stalled) begin
        chk_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_re !== p_re || bus.out_im !== p_im || bus.out_tag !== p_tag)
          $display("FAIL bp_stable[%0d]: got v%0b (%0d,%0d,t%0d) want v1 (%0d,%0d,t%0d)", i,
                   bus.out_valid, bus.out_re, bus.out_im, bus.out_tag, p_re, p_im, p_tag);
        else pass_cnt++;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      set_random();
      bus.in_valid = 1'b1;
      #1;
      chk_cnt++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready))
        $display("FAIL bp_in_ready[%0d]: got %0b want %0b", i, bus.in_ready, (!bus.out_valid || bus.out_ready));
      else pass_cnt++;
      stalled = bus.out_valid && !bus.out_ready;
      p_re = bus.out_re; p_im = bus.out_im; p_tag = bus.out_tag;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk_cnt++; if (exp_q.size() < 20) $display("FAIL bp_accepts: got %0d want at least 20", exp_q.size()); else pass_cnt++;
    compare_queues("bp", exp_q.size());
  endtask

  task automatic test_mode_per_sample();
    int n;
    bus.out_ready = 1'b1;
    idle(3);
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 8; i++) begin
      set_in(2 * i + 1, 0, 64, 0, i, 1'(i % 2), 1'b0);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (got_q.size() < 8 && n < 20) begin @(posedge clk); #1; n++; end
    chk_cnt++; if (got_q.size() != 8) $display("FAIL mode_count: got %0d want 8", got_q.size()); else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      chk_cnt++;
      if (got_q[i].re !== longint'((i % 2 == 1) ? i + 1 : i) || got_q[i].tag !== i)
        $display("FAIL mode[%0d]: got re=%0d tag=%0d want re=%0d tag=%0d", i, got_q[i].re, got_q[i].tag,
                 (i % 2 == 1) ? i + 1 : i, i);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_inflight();
    int lat;
    bus.out_ready = 1'b1;
    idle(3);
    for (int i = 0; i < 3; i++) begin
      set_in(-65536, 0, -128, 0, i + 1, 1'b0, 1'b1);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk_cnt++; if (bus.out_valid !== 1'b1 || bus.ovf !== 1'b1) $display("FAIL rst_pre: got v%0b ovf%0b want v1 ovf1", bus.out_valid, bus.ovf); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_async_valid: got %0b want 0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.ovf !== 1'b0) $display("FAIL rst_async_ovf: got %0b want 0", bus.ovf); else pass_cnt++;
    chk_cnt++; if (bus.out_re !== '0) $display("FAIL rst_async_re: got %0d want 0", bus.out_re); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
    run_one(5, 0, 64, 0, 9, 1'b0, 1'b0, lat);
    chk_cnt++; if (lat != 3) $display("FAIL rst_new_latency: got %0d want 3", lat); else pass_cnt++;
    chk_cnt++; if (longint'(bus.out_re) !== 2 || bus.out_tag !== 4'd9) $display("FAIL rst_new_value: got re=%0d tag=%0d want re=2 tag=9", bus.out_re, bus.out_tag); else pass_cnt++;
    idle(4);
    chk_cnt++; if (got_q.size() != 1) $display("FAIL rst_no_stale: got %0d results want 1", got_q.size()); else pass_cnt++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rounding();
    test_overflow();
    test_streaming();
    test_back_to_back_backpressure();
    test_mode_per_sample();
    test_reset_inflight();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
